sr_ff_bank: RTL

Parametrised bank of CH clocked SR flip-flops and the successor to the single ungated SR latch. Each channel has an input stability filter and a run-time selectable resolution for the S=R=1 condition. Each channel also has sticky illegal-condition flags, and the bank has a shared saturating event counter. It is used wherever multiple set/reset control bits need registered, deterministic behaviour.

---
 rtl/sr_ff_bank_if.sv | 17 +
 rtl/sr_ff_bank.sv | 55 +++++
 2 files changed

// File: rtl/sr_ff_bank_if.sv
// sr_ff_bank_if: SR bank request/state bus; master drives S/R/mode/clears, slave returns Q/Qn/err/err_cnt
interface sr_ff_bank_if #(
  parameter int CH = 4,
  parameter int CNT_W = 8
);
  logic [CH-1:0] S;
  logic [CH-1:0] R;
  logic [1:0] mode;
  logic [CH-1:0] clr_err;
  logic clr_cnt;
  logic [CH-1:0] Q;
  logic [CH-1:0] Qn;
  logic [CH-1:0] err;
  logic [CNT_W-1:0] err_cnt;
  modport master (output S, R, mode, clr_err, clr_cnt, input Q, Qn, err, err_cnt);
  modport slave (input S, R, mode, clr_err, clr_cnt, output Q, Qn, err, err_cnt);
endinterface

// File: rtl/sr_ff_bank.sv
// sr_ff_bank: CH filtered clocked SR flops, mode-resolved S=R=1, sticky err, saturating err_cnt; irq output when SR_BANK_IRQ_EN is defined
module sr_ff_bank #(
  parameter int CH = 4,
  parameter int FILT = 2,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
`ifdef SR_BANK_IRQ_EN
  output logic irq,
`endif
  sr_ff_bank_if.slave bus
);
  localparam int FW = FILT > 0 ? $clog2(FILT + 1) : 1;
  localparam logic [FW-1:0] FMAX = FW'(FILT);
  logic [CH-1:0] ps_q, pr_q, q_q, q_d, qn_q, err_q, err_d, app, ev;
  logic [FW-1:0] fc_q [CH];
  logic [FW-1:0] fc_d [CH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      fc_d[i] = (bus.S[i] != ps_q[i] || bus.R[i] != pr_q[i]) ? '0 :
                (fc_q[i] == FMAX) ? fc_q[i] : fc_q[i] + 1'b1;
      app[i] = fc_d[i] == FMAX;
      ev[i] = app[i] & bus.S[i] & bus.R[i];
      q_d[i] = !app[i] ? q_q[i] :
               (bus.S[i] & !bus.R[i]) ? 1'b1 :
               (!bus.S[i] & bus.R[i]) ? 1'b0 :
               (!bus.S[i] & !bus.R[i]) ? q_q[i] :
               (bus.mode == 2'd1) ? 1'b1 :
               (bus.mode == 2'd2) ? 1'b0 :
               (bus.mode == 2'd3) ? ~q_q[i] : q_q[i];
    end
    err_d = (err_q & ~bus.clr_err) | ev;
    cnt_d = bus.clr_cnt ? CNT_W'(|ev) : (|ev && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) fc_q[i] <= rst ? '0 : fc_d[i];
    ps_q <= rst ? '0 : bus.S;
    pr_q <= rst ? '0 : bus.R;
    q_q <= rst ? '0 : q_d;
    qn_q <= rst ? '1 : ~q_d;
    err_q <= rst ? '0 : err_d;
    cnt_q <= rst ? '0 : cnt_d;
  end
`ifdef SR_BANK_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) irq_q <= rst ? 1'b0 : |err_d;
  assign irq = irq_q;
`endif
  assign bus.Q = q_q;
  assign bus.Qn = qn_q;
  assign bus.err = err_q;
  assign bus.err_cnt = cnt_q;
endmodule
